// File: rtl/kf8255_initiator_pkg.sv
// Shared types and constants for the KF8255 bus initiator.
// Includes control-word fields used by PPI init logic.
package kf8255_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  localparam logic [1:0] PORT_A  = 2'd0;
  localparam logic [1:0] PORT_B  = 2'd1;
  localparam logic [1:0] PORT_C  = 2'd2;
  localparam logic [1:0] CONTROL = 2'd3;

  localparam int         CW_MODE_SET_BIT = 7;
  localparam logic [7:0] CW_MODE_SET     = 8'h80;

  localparam logic [1:0] GRPA_MODE0 = 2'b00;
  localparam logic [1:0] GRPA_MODE1 = 2'b01;
  localparam logic [1:0] GRPA_MODE2 = 2'b10;
  localparam logic       GRPB_MODE0 = 1'b0;
  localparam logic       GRPB_MODE1 = 1'b1;

  localparam logic PORT_OUT = 1'b0;
  localparam logic PORT_IN  = 1'b1;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/kf8255_bus_initiator_if.sv
// Request/response handshake and 8255 bus pins.
// master = initiator view, slave = requester/PPI view.
interface kf8255_bus_initiator_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_address;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       chip_select_n;
  logic       read_n;
  logic       write_n;
  logic [1:0] address;
  logic [7:0] data_bus_out;
  logic       data_bus_io;
  logic [7:0] data_bus_in;

  modport master (
    input  req_valid, req_write,
    input  req_address, req_data,
    input  data_bus_in,
    output req_ready, rsp_valid, rsp_data,
    output chip_select_n, read_n, write_n,
    output address, data_bus_out,
    output data_bus_io
  );

  modport slave (
    output req_valid, req_write,
    output req_address, req_data,
    output data_bus_in,
    input  req_ready, rsp_valid, rsp_data,
    input  chip_select_n, read_n, write_n,
    input  address, data_bus_out,
    input  data_bus_io
  );
endinterface

// File: rtl/kf8255_initiator_timer.sv
// Loadable phase down-counter; stops at 1.
// o_tc flags the last cycle of the current phase.
module kf8255_initiator_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // reload per phase, otherwise count down and park at 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count > W'(1)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc = (r_count == W'(1));

endmodule

// File: rtl/kf8255_bus_initiator.sv
// 8255 bus-cycle sequencer: one request in,
// one timed CS#/RD#/WR# cycle out, one response strobe.
module kf8255_bus_initiator
  import kf8255_initiator_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input logic clock,
  input logic reset_n,
  kf8255_bus_initiator_if.master bus
);

  localparam int CW = $clog2(
    max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);

  state_e     r_state;
  logic       r_req_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic [1:0] r_addr;
  logic [7:0] r_dout;
  logic       r_io;
  logic       r_write;

  state_e     w_state_nxt;
  logic       w_load;
  logic [CW-1:0] w_load_val;
  logic       w_tc;
  logic       w_rdy;
  logic       w_rv;
  logic [7:0] w_rdata;
  logic       w_cs_n;
  logic       w_rd_n;
  logic       w_wr_n;
  logic [1:0] w_addr;
  logic [7:0] w_dout;
  logic       w_io;
  logic       w_write;

  kf8255_initiator_timer #(
    .W (CW)
  ) u_timer (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_tc    (w_tc)
  );

  // next state and next registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_rdy       = r_req_ready;
    w_rv        = 1'b0;
    w_rdata     = r_rsp_data;
    w_cs_n      = r_cs_n;
    w_rd_n      = r_rd_n;
    w_wr_n      = r_wr_n;
    w_addr      = r_addr;
    w_dout      = r_dout;
    w_io        = r_io;
    w_write     = r_write;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = ST_SETUP;
          w_load      = 1'b1;
          w_load_val  = CW'(SETUP_CYCLES);
          w_rdy       = 1'b0;
          w_cs_n      = 1'b0;
          w_addr      = bus.req_address;
          w_write     = bus.req_write;
          w_io        = bus.req_write;
          w_dout      = bus.req_write ? bus.req_data : 8'h00;
        end
      end
      ST_SETUP: begin
        if (w_tc) begin
          w_state_nxt = ST_STROBE;
          w_load      = 1'b1;
          w_load_val  = CW'(PULSE_CYCLES);
          w_rd_n      = r_write;
          w_wr_n      = ~r_write;
        end
      end
      ST_STROBE: begin
        if (w_tc) begin
          w_state_nxt = ST_HOLD;
          w_load      = 1'b1;
          w_load_val  = CW'(HOLD_CYCLES);
          w_rd_n      = 1'b1;
          w_wr_n      = 1'b1;
          if (!r_write) w_rdata = bus.data_bus_in;
        end
      end
      ST_HOLD: begin
        if (w_tc) begin
          w_state_nxt = ST_IDLE;
          w_rdy       = 1'b1;
          w_rv        = 1'b1;
          w_cs_n      = 1'b1;
          w_addr      = 2'd0;
          w_dout      = 8'h00;
          w_io        = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state and output registers; reset idles the bus at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_cs_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_addr      <= 2'd0;
      r_dout      <= 8'h00;
      r_io        <= 1'b0;
      r_write     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_rdy;
      r_rsp_valid <= w_rv;
      r_rsp_data  <= w_rdata;
      r_cs_n      <= w_cs_n;
      r_rd_n      <= w_rd_n;
      r_wr_n      <= w_wr_n;
      r_addr      <= w_addr;
      r_dout      <= w_dout;
      r_io        <= w_io;
      r_write     <= w_write;
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.chip_select_n = r_cs_n;
  assign bus.read_n        = r_rd_n;
  assign bus.write_n       = r_wr_n;
  assign bus.address       = r_addr;
  assign bus.data_bus_out  = r_dout;
  assign bus.data_bus_io   = r_io;

endmodule

// File: tb/tb_kf8255_bus_initiator.sv
// Bench for kf8255_bus_initiator: default and
// stretched timing instances, scoreboarded responses.
module tb_kf8255_bus_initiator;
  import kf8255_initiator_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  kf8255_bus_initiator_if b0 ();
  kf8255_bus_initiator_if b1 ();

  kf8255_bus_initiator u_dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b0.master)
  );

  kf8255_bus_initiator #(
    .SETUP_CYCLES (2),
    .PULSE_CYCLES (4),
    .HOLD_CYCLES  (3)
  ) u_dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b1.master)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];
  logic [7:0] m_rd = 8'h00;

  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic io;
    logic rv;
    logic rdy;
  } exp_t;

  function automatic exp_t exp_at(
    input int s, input int p, input int h,
    input int c, input logic wr
  );
    exp_t e;
    logic act;
    logic stb;
    act    = (c >= 1) && (c <= s + p + h);
    stb    = (c >= s + 1) && (c <= s + p);
    e.cs_n = !act;
    e.rd_n = !(stb && !wr);
    e.wr_n = !(stb && wr);
    e.io   = wr && act;
    e.rv   = (c == s + p + h + 1);
    e.rdy  = !act;
    return e;
  endfunction

  task automatic idle_inputs();
    b0.req_valid = 0; b0.req_write = 0;
    b0.req_address = 0; b0.req_data = 0;
    b0.data_bus_in = 0;
    b1.req_valid = 0; b1.req_write = 0;
    b1.req_address = 0; b1.req_data = 0;
    b1.data_bus_in = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clock);
      b0.req_valid = 1'($urandom);
      b0.req_write = 1'($urandom);
      b0.req_address = 2'($urandom);
      b0.req_data = 8'($urandom);
      b0.data_bus_in = 8'($urandom);
      b1.req_valid = 1'($urandom);
      b1.req_write = 1'($urandom);
      b1.req_address = 2'($urandom);
      b1.req_data = 8'($urandom);
      b1.data_bus_in = 8'($urandom);
    end
    @(negedge clock);
    total++;
    if ({b0.chip_select_n, b0.read_n, b0.write_n,
         b0.data_bus_io, b0.req_ready, b0.rsp_valid}
        !== 6'b111010) begin
      bad++;
      $display("FAIL rst_ctl0 got=%b want=111010",
        {b0.chip_select_n, b0.read_n, b0.write_n,
         b0.data_bus_io, b0.req_ready, b0.rsp_valid});
    end
    total++;
    if ({b0.rsp_data, b0.address, b0.data_bus_out}
        !== 18'h0) begin
      bad++;
      $display("FAIL rst_data0 got=%h/%h/%h want=0",
        b0.rsp_data, b0.address, b0.data_bus_out);
    end
    total++;
    if ({b1.chip_select_n, b1.read_n, b1.write_n,
         b1.data_bus_io, b1.req_ready, b1.rsp_valid,
         b1.rsp_data} !== {6'b111010, 8'h00}) begin
      bad++;
      $display("FAIL rst_1 got=%b/%h want=111010/00",
        {b1.chip_select_n, b1.read_n, b1.write_n,
         b1.data_bus_io, b1.req_ready, b1.rsp_valid},
        b1.rsp_data);
    end
    idle_inputs();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_write();
    exp_t e;
    exp_t o;
    logic [7:0] x;
    @(negedge clock);
    b0.req_valid = 1; b0.req_write = 1;
    b0.req_address = CONTROL; b0.req_data = 8'h9B;
    sb.push_back(m_rd);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      e = exp_at(1, 2, 1, c, 1'b1);
      o = {b0.chip_select_n, b0.read_n, b0.write_n,
           b0.data_bus_io, b0.rsp_valid, b0.req_ready};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL wr_ctl c%0d got=%b want=%b", c, o, e);
      end
      total++;
      if ({b0.address, b0.data_bus_out} !==
          ((c <= 4) ? {CONTROL, 8'h9B} : 10'h0)) begin
        bad++;
        $display("FAIL wr_bus c%0d got=%h/%h",
          c, b0.address, b0.data_bus_out);
      end
      if (b0.rsp_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL wr_rsp unexpected rsp_valid");
        end else begin
          x = sb.pop_front();
          if (b0.rsp_data !== x) begin
            bad++;
            $display("FAIL wr_rsp got=%h want=%h",
              b0.rsp_data, x);
          end
        end
      end
      if (c == 1) b0.req_valid = 0;
    end
  endtask

  task automatic test_read();
    exp_t e;
    exp_t o;
    logic [7:0] x;
    @(negedge clock);
    b0.data_bus_in = 8'h3C;
    b0.req_valid = 1; b0.req_write = 0;
    b0.req_address = PORT_A; b0.req_data = 8'hFF;
    m_rd = 8'hA5;
    sb.push_back(m_rd);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      e = exp_at(1, 2, 1, c, 1'b0);
      o = {b0.chip_select_n, b0.read_n, b0.write_n,
           b0.data_bus_io, b0.rsp_valid, b0.req_ready};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rd_ctl c%0d got=%b want=%b", c, o, e);
      end
      if (b0.rsp_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rd_rsp unexpected rsp_valid");
        end else begin
          x = sb.pop_front();
          if (b0.rsp_data !== x) begin
            bad++;
            $display("FAIL rd_rsp got=%h want=%h",
              b0.rsp_data, x);
          end
        end
      end
      if (c == 1) b0.req_valid = 0;
      if (c == 3) b0.data_bus_in = 8'hA5;
      if (c == 4) b0.data_bus_in = 8'h00;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t o;
    logic [7:0] x;
    logic [7:0] d;
    @(negedge clock);
    b0.req_valid = 1; b0.req_write = 1;
    b0.req_address = CONTROL; b0.req_data = 8'h80;
    sb.push_back(m_rd);
    sb.push_back(m_rd);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      if (c <= 5) e = exp_at(1, 2, 1, c, 1'b1);
      else e = exp_at(1, 2, 1, c - 5, 1'b1);
      o = {b0.chip_select_n, b0.read_n, b0.write_n,
           b0.data_bus_io, b0.rsp_valid, b0.req_ready};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL b2b_ctl c%0d got=%b want=%b", c, o, e);
      end
      d = 8'h00;
      if (c <= 4) d = 8'h80;
      if (c >= 6 && c <= 9) d = 8'h01;
      total++;
      if (b0.data_bus_out !== d) begin
        bad++;
        $display("FAIL b2b_data c%0d got=%h want=%h",
          c, b0.data_bus_out, d);
      end
      if (b0.rsp_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL b2b_rsp unexpected rsp_valid");
        end else begin
          x = sb.pop_front();
          if (b0.rsp_data !== x) begin
            bad++;
            $display("FAIL b2b_rsp got=%h want=%h",
              b0.rsp_data, x);
          end
        end
      end
      if (c == 1) b0.req_data = 8'h01;
      if (c == 6) b0.req_valid = 0;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    b0.req_valid = 1; b0.req_write = 1;
    b0.req_address = PORT_B; b0.req_data = 8'h55;
    @(negedge clock);
    b0.req_valid = 0;
    @(negedge clock);
    total++;
    if (b0.write_n !== 1'b0) begin
      bad++;
      $display("FAIL ar_pre write_n got=%b want=0",
        b0.write_n);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({b0.chip_select_n, b0.write_n, b0.read_n,
         b0.data_bus_io} !== 4'b1110) begin
      bad++;
      $display("FAIL ar_async got=%b want=1110",
        {b0.chip_select_n, b0.write_n, b0.read_n,
         b0.data_bus_io});
    end
    @(negedge clock);
    reset_n = 1'b1;
    m_rd = 8'h00;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      total++;
      if ({b0.rsp_valid, b0.req_ready, b0.chip_select_n}
          !== 3'b011) begin
        bad++;
        $display("FAIL ar_post c%0d got=%b want=011", c,
          {b0.rsp_valid, b0.req_ready, b0.chip_select_n});
      end
    end
    total++;
    if (b0.rsp_data !== m_rd) begin
      bad++;
      $display("FAIL ar_rdata got=%h want=%h",
        b0.rsp_data, m_rd);
    end
  endtask

  task automatic test_long_read();
    exp_t e;
    exp_t o;
    logic [7:0] x;
    @(negedge clock);
    b1.data_bus_in = 8'hC3;
    b1.req_valid = 1; b1.req_write = 0;
    b1.req_address = PORT_C; b1.req_data = 8'h00;
    sb.push_back(8'h5A);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      e = exp_at(2, 4, 3, c, 1'b0);
      o = {b1.chip_select_n, b1.read_n, b1.write_n,
           b1.data_bus_io, b1.rsp_valid, b1.req_ready};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL lr_ctl c%0d got=%b want=%b", c, o, e);
      end
      total++;
      if (b1.address !== ((c <= 9) ? PORT_C : 2'd0)) begin
        bad++;
        $display("FAIL lr_addr c%0d got=%h", c, b1.address);
      end
      if (b1.rsp_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL lr_rsp unexpected rsp_valid");
        end else begin
          x = sb.pop_front();
          if (b1.rsp_data !== x) begin
            bad++;
            $display("FAIL lr_rsp got=%h want=%h",
              b1.rsp_data, x);
          end
        end
      end
      if (c == 1) b1.req_valid = 0;
      if (c == 6) b1.data_bus_in = 8'h5A;
      if (c == 7) b1.data_bus_in = 8'h00;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_async_reset();
    test_long_read();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_left got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
